// File: rtl/reg_cmd_decoder_pkg.sv
// reg_cmd_decoder_pkg: command byte fields, status codes and FSM states shared by the decoder
package reg_cmd_decoder_pkg;
  localparam int RC_WR_BIT = 7;
  localparam int RC_ADDR_W = 7;
  localparam logic [7:0] RC_ST_OK = 8'h00;
  localparam logic [7:0] RC_ST_BADADDR = 8'h01;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WDATA,
    ST_WMASK,
    ST_WISSUE,
    ST_ACK,
    ST_RDATA
  } state_t;
endpackage

// File: rtl/reg_cmd_decoder_byte_shift.sv
// byte_shift: WIDTH-bit register with parallel load, byte shift-in at the MSB end and byte shift-out at the LSB end
//   clk, rst_n    : clock, async active-low reset
//   load_i        : load load_val_i (wins over shifting)
//   shift_in_i    : shift right one byte, byte_i enters at the MSB end
//   shift_out_i   : shift right one byte, zeros enter at the MSB end
//   q_o           : current contents
module byte_shift #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             shift_in_i,
  input  logic             shift_out_i,
  input  logic [7:0]       byte_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] q_q, q_d, sh;
  // Truncating cast keeps this valid for WIDTH == 8, where there is no q_q[WIDTH-1:8]
  always_comb begin
    sh = WIDTH'({shift_in_i ? byte_i : 8'h00, q_q} >> 8);
    q_d = load_i ? load_val_i : (shift_in_i || shift_out_i) ? sh : q_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q_q <= '0;
    else q_q <= q_d;
  assign q_o = q_q;
endmodule

// File: rtl/reg_cmd_decoder.sv
// reg_cmd_decoder: host byte stream to masked register writes and byte-serialised register reads
//   sclk, srst_n                 : clock, async active-low reset
//   rx_data/rx_valid/rx_ready    : command and payload bytes from host
//   tx_data/tx_valid/tx_ready    : status or read-data bytes to host
//   reg_wsel/wdata/wmask/wen     : masked write port to the bank, gated by reg_wbusy
//   reg_rdata                    : flattened slow-side register values
module reg_cmd_decoder
  import reg_cmd_decoder_pkg::*;
#(
  parameter int NREGS = 16,
  parameter int WIDTH = 16
) (
  input  logic                   sclk,
  input  logic                   srst_n,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  output logic                   rx_ready,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic [RC_ADDR_W-1:0]   reg_wsel,
  output logic [WIDTH-1:0]       reg_wdata,
  output logic [WIDTH-1:0]       reg_wmask,
  output logic                   reg_wen,
  input  logic                   reg_wbusy,
  input  logic [NREGS*WIDTH-1:0] reg_rdata
);
  localparam int NB = WIDTH / 8;
  localparam int CW = $clog2(NB) + 1;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RC_ADDR_W-1:0] wsel_q, wsel_d;
  logic bad_q, bad_d;
  logic rx_fire, tx_fire, last, cmd_bad, cmd_wr, mask_nz;
  logic rd_load, rd_shift;
  logic [WIDTH-1:0] rsel, rd_load_val, rd_q;
  assign rx_fire = rx_valid && rx_ready;
  assign tx_fire = tx_valid && tx_ready;
  assign last = cnt_q == CW'(NB - 1);
  assign cmd_wr = rx_data[RC_WR_BIT];
  assign cmd_bad = 32'(rx_data[RC_ADDR_W-1:0]) >= 32'(NREGS);
  assign mask_nz = |reg_wmask;
  // Read snapshot source: out-of-range addresses fall through to zero
  always_comb begin
    rsel = '0;
    for (int i = 0; i < NREGS; i++)
      if (rx_data[RC_ADDR_W-1:0] == RC_ADDR_W'(i)) rsel = reg_rdata[i*WIDTH +: WIDTH];
  end
  always_ff @(posedge sclk or negedge srst_n)
    if (!srst_n) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      wsel_q <= '0;
      bad_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      wsel_q <= wsel_d;
      bad_q <= bad_d;
    end
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (rx_fire) state_d = cmd_wr ? ST_WDATA : ST_RDATA;
      ST_WDATA:  if (rx_fire && last) state_d = ST_WMASK;
      ST_WMASK:  if (rx_fire && last) state_d = ST_WISSUE;
      ST_WISSUE: if (bad_q || !mask_nz || !reg_wbusy) state_d = ST_ACK;
      ST_ACK:    if (tx_ready) state_d = ST_IDLE;
      ST_RDATA:  if (tx_ready && last) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end
  always_comb begin
    rx_ready = state_q inside {ST_IDLE, ST_WDATA, ST_WMASK};
    tx_valid = state_q inside {ST_ACK, ST_RDATA};
    reg_wen = state_q == ST_WISSUE && !reg_wbusy && !bad_q && mask_nz;
  end
  // Counter clears on every state change, so only WDATA/WMASK/RDATA ever see it advance
  always_comb begin
    cnt_d = (state_d != state_q) ? '0 : (rx_fire || tx_fire) ? cnt_q + 1'b1 : cnt_q;
    wsel_d = (state_q == ST_IDLE && rx_fire && cmd_wr) ? rx_data[RC_ADDR_W-1:0] : wsel_q;
    bad_d = (state_q == ST_IDLE && rx_fire && cmd_wr) ? cmd_bad : bad_q;
  end
  // The read shifter also carries the write status byte, so tx_data is always its LSB
  always_comb begin
    rd_load = (state_q == ST_IDLE && rx_fire && !cmd_wr) || (state_q == ST_WISSUE && state_d == ST_ACK);
    rd_load_val = (state_q == ST_WISSUE) ? WIDTH'(bad_q ? RC_ST_BADADDR : RC_ST_OK) : rsel;
    rd_shift = state_q == ST_RDATA && tx_ready;
  end
  byte_shift #(.WIDTH(WIDTH)) u_data (
    .clk(sclk), .rst_n(srst_n), .load_i(1'b0), .load_val_i('0),
    .shift_in_i(state_q == ST_WDATA && rx_fire), .shift_out_i(1'b0),
    .byte_i(rx_data), .q_o(reg_wdata)
  );
  byte_shift #(.WIDTH(WIDTH)) u_mask (
    .clk(sclk), .rst_n(srst_n), .load_i(1'b0), .load_val_i('0),
    .shift_in_i(state_q == ST_WMASK && rx_fire), .shift_out_i(1'b0),
    .byte_i(rx_data), .q_o(reg_wmask)
  );
  byte_shift #(.WIDTH(WIDTH)) u_rd (
    .clk(sclk), .rst_n(srst_n), .load_i(rd_load), .load_val_i(rd_load_val),
    .shift_in_i(1'b0), .shift_out_i(rd_shift),
    .byte_i(8'h00), .q_o(rd_q)
  );
  assign tx_data = 8'(rd_q);
  assign reg_wsel = wsel_q;
endmodule

// File: tb/tb_reg_cmd_decoder.sv
// tb_reg_cmd_decoder: directed table-driven checks of the register command decoder
module tb_reg_cmd_decoder;
  localparam int NREGS = 16;
  localparam int WIDTH = 16;
  logic sclk = 0, srst_n = 0;
  logic [7:0] rx_data = 0, tx_data;
  logic rx_valid = 0, rx_ready, tx_valid, tx_ready = 0;
  logic [6:0] reg_wsel;
  logic [WIDTH-1:0] reg_wdata, reg_wmask;
  logic reg_wen, reg_wbusy = 0;
  logic [NREGS*WIDTH-1:0] reg_rdata;
  int n_chk = 0, n_fail = 0, wen_cnt = 0;
  logic [6:0] seen_wsel;
  logic [15:0] seen_wdata, seen_wmask;
  reg_cmd_decoder #(.NREGS(NREGS), .WIDTH(WIDTH)) dut (
    .sclk(sclk), .srst_n(srst_n), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .reg_wsel(reg_wsel),
    .reg_wdata(reg_wdata), .reg_wmask(reg_wmask), .reg_wen(reg_wen), .reg_wbusy(reg_wbusy),
    .reg_rdata(reg_rdata)
  );
  always #5 sclk = ~sclk;
  always @(negedge sclk)
    if (reg_wen) begin
      wen_cnt++;
      seen_wsel = reg_wsel;
      seen_wdata = reg_wdata;
      seen_wmask = reg_wmask;
    end
  typedef struct {
    logic wr;
    logic [7:0] cmd;
    logic [15:0] data;
    logic [15:0] mask;
    logic [15:0] exp;
    logic exp_wen;
  } vec_t;
  vec_t vecs[9];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic send(input logic [7:0] b);
    bit done = 0;
    rx_data = b;
    rx_valid = 1;
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge sclk);
      done = rx_ready;
      @(posedge sclk);
      #1;
    end
    rx_valid = 0;
    chk("rx_accept", 32'(done), 1);
  endtask
  task automatic recv(output logic [7:0] b);
    bit got = 0;
    b = 8'h00;
    tx_ready = 1;
    for (int n = 0; n < 50 && !got; n++) begin
      @(negedge sclk);
      if (tx_valid) begin
        got = 1;
        b = tx_data;
      end
      @(posedge sclk);
      #1;
    end
    tx_ready = 0;
    chk("tx_timeout", 32'(got), 1);
  endtask
  initial begin
    logic [7:0] b0, b1;
    int w0;
    logic [7:0] q[$];
    logic [7:0] prev;
    bit stall;
    for (int i = 0; i < NREGS; i++)
      reg_rdata[i*WIDTH +: WIDTH] = (i == 5) ? 16'hBEEF : 16'(i * 16'h0101 + 16'h00A0);
    vecs[0] = '{1, 8'h83, 16'h1234, 16'h0FFF, 16'h0000, 1};
    vecs[1] = '{0, 8'h05, 16'h0000, 16'h0000, 16'hBEEF, 0};
    vecs[2] = '{1, 8'h90, 16'hCAFE, 16'hFFFF, 16'h0001, 0};
    vecs[3] = '{0, 8'h20, 16'h0000, 16'h0000, 16'h0000, 0};
    vecs[4] = '{1, 8'h87, 16'hA5A5, 16'h0000, 16'h0000, 0};
    vecs[5] = '{0, 8'h00, 16'h0000, 16'h0000, 16'h00A0, 0};
    vecs[6] = '{1, 8'h8F, 16'hFFFF, 16'h8001, 16'h0000, 1};
    vecs[7] = '{0, 8'h0F, 16'h0000, 16'h0000, 16'h0FAF, 0};
    vecs[8] = '{0, 8'h10, 16'h0000, 16'h0000, 16'h0000, 0};
    repeat (2) @(negedge sclk);
    chk("rst_rx_ready", 32'(rx_ready), 1);
    chk("rst_tx_valid", 32'(tx_valid), 0);
    chk("rst_wen", 32'(reg_wen), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_wsel", 32'(reg_wsel), 0);
    chk("rst_wdata", 32'(reg_wdata), 0);
    chk("rst_wmask", 32'(reg_wmask), 0);
    @(posedge sclk);
    #1 srst_n = 1;
    @(posedge sclk);
    #1;
    for (int v = 0; v < 9; v++) begin
      w0 = wen_cnt;
      send(vecs[v].cmd);
      if (vecs[v].wr) begin
        send(vecs[v].data[7:0]);
        send(vecs[v].data[15:8]);
        send(vecs[v].mask[7:0]);
        send(vecs[v].mask[15:8]);
        recv(b0);
        chk($sformatf("v%0d_status", v), 32'(b0), 32'(vecs[v].exp[7:0]));
        chk($sformatf("v%0d_wen_count", v), wen_cnt - w0, 32'(vecs[v].exp_wen));
        if (vecs[v].exp_wen) begin
          chk($sformatf("v%0d_wsel", v), 32'(seen_wsel), 32'(vecs[v].cmd[6:0]));
          chk($sformatf("v%0d_wdata", v), 32'(seen_wdata), 32'(vecs[v].data));
          chk($sformatf("v%0d_wmask", v), 32'(seen_wmask), 32'(vecs[v].mask));
        end
      end else begin
        @(negedge sclk);
        chk($sformatf("v%0d_first_valid", v), 32'(tx_valid), 1);
        chk($sformatf("v%0d_first_data", v), 32'(tx_data), 32'(vecs[v].exp[7:0]));
        @(posedge sclk);
        #1;
        recv(b0);
        recv(b1);
        chk($sformatf("v%0d_rdata", v), 32'({b1, b0}), 32'(vecs[v].exp));
        chk($sformatf("v%0d_no_wen", v), wen_cnt - w0, 0);
      end
    end
    // Busy stall: strobe must wait for busy to drop, then fire exactly once
    w0 = wen_cnt;
    reg_wbusy = 1;
    send(8'h82);
    send(8'h5A);
    send(8'h5A);
    send(8'hFF);
    send(8'hFF);
    for (int n = 0; n < 10; n++) begin
      @(negedge sclk);
      chk("busy_no_wen", 32'(reg_wen), 0);
      chk("busy_no_ack", 32'(tx_valid), 0);
      @(posedge sclk);
      #1;
    end
    reg_wbusy = 0;
    @(negedge sclk);
    chk("busy_drop_wen", 32'(reg_wen), 1);
    @(posedge sclk);
    #1;
    recv(b0);
    chk("busy_status", 32'(b0), 0);
    chk("busy_wen_count", wen_cnt - w0, 1);
    chk("busy_wsel_hold", 32'(reg_wsel), 2);
    chk("busy_wdata_hold", 32'(reg_wdata), 32'h5A5A);
    // Backpressure read with a snapshot change after acceptance
    send(8'h05);
    reg_rdata[5*WIDTH +: WIDTH] = 16'h1111;
    stall = 0;
    prev = 8'h00;
    for (int n = 0; n < 200 && q.size() < 2; n++) begin
      tx_ready = 1'($urandom_range(0, 1));
      @(negedge sclk);
      if (stall) chk("bp_stable", 32'(tx_data), 32'(prev));
      stall = tx_valid && !tx_ready;
      prev = tx_data;
      if (tx_valid && tx_ready) q.push_back(tx_data);
      @(posedge sclk);
      #1;
    end
    tx_ready = 0;
    chk("bp_count", q.size(), 2);
    if (q.size() == 2) chk("bp_bytes", 32'({q[1], q[0]}), 32'hBEEF);
    @(negedge sclk);
    chk("bp_done_idle", 32'({rx_ready, tx_valid}), 32'b10);
    @(posedge sclk);
    #1;
    reg_rdata[5*WIDTH +: WIDTH] = 16'hBEEF;
    // Reset mid-write aborts the command
    w0 = wen_cnt;
    send(8'h83);
    send(8'h11);
    send(8'h22);
    #2 srst_n = 0;
    #1;
    chk("mid_rst_tx_valid", 32'(tx_valid), 0);
    chk("mid_rst_wen", 32'(reg_wen), 0);
    chk("mid_rst_tx_data", 32'(tx_data), 0);
    chk("mid_rst_wsel", 32'(reg_wsel), 0);
    chk("mid_rst_wdata", 32'(reg_wdata), 0);
    chk("mid_rst_wmask", 32'(reg_wmask), 0);
    repeat (2) @(posedge sclk);
    #1 srst_n = 1;
    @(negedge sclk);
    chk("post_rst_ready", 32'(rx_ready), 1);
    @(posedge sclk);
    #1;
    send(8'h05);
    recv(b0);
    recv(b1);
    chk("post_rst_read", 32'({b1, b0}), 32'hBEEF);
    chk("post_rst_no_wen", wen_cnt - w0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
